// File: rtl/reg_file_wb_if.sv
// Write-back to register-file bundle: write port, return/halt commands, decode read ports and status.
// The master side is the write-back/decode stage; the slave side is the register file.
interface reg_file_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] iWriteData;
  logic [ADDR_WIDTH-1:0] iWriteAddr;
  logic                  iWriteEn;
  logic                  iRetCmd;
  logic [31:0]           iRetAddr;
  logic                  iHalt;
  logic [ADDR_WIDTH-1:0] iReadAddrA;
  logic [ADDR_WIDTH-1:0] iReadAddrB;
  logic [DATA_WIDTH-1:0] oReadDataA;
  logic [DATA_WIDTH-1:0] oReadDataB;
  logic                  oRedirectEn;
  logic [31:0]           oRedirectAddr;
  logic                  oHalted;
  logic [CNT_WIDTH-1:0]  oRetireCount;

  modport master (
    output iWriteData, iWriteAddr, iWriteEn, iRetCmd, iRetAddr, iHalt,
           iReadAddrA, iReadAddrB,
    input  oReadDataA, oReadDataB, oRedirectEn, oRedirectAddr, oHalted, oRetireCount
  );

  modport slave (
    input  iWriteData, iWriteAddr, iWriteEn, iRetCmd, iRetAddr, iHalt,
           iReadAddrA, iReadAddrB,
    output oReadDataA, oReadDataB, oRedirectEn, oRedirectAddr, oHalted, oRetireCount
  );
endinterface

// File: rtl/reg_file_wb.sv
// Architectural register file with same-cycle write bypass, registered return redirect,
// sticky halt flag and a committed-write counter.
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic          iClk,
  input  logic          iRst_n,
  reg_file_wb_if.slave  bus
);
  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regFile_q [NumRegs];
  logic                  halted_q, halted_d;
  logic                  redirectEn_q, redirectEn_d;
  logic [31:0]           redirectAddr_q, redirectAddr_d;
  logic [CNT_WIDTH-1:0]  retireCount_q, retireCount_d;
  logic                  wr;
  logic                  retTake;

  // Reset gates the commit so nothing bypasses onto the read ports while it is held.
  assign wr      = iRst_n & bus.iWriteEn & ~halted_q & (bus.iWriteAddr != '0);
  assign retTake = bus.iRetCmd & ~halted_q;

  always_comb begin
    halted_d       = halted_q | bus.iHalt;
    redirectEn_d   = retTake;
    redirectAddr_d = retTake ? bus.iRetAddr : redirectAddr_q;
    retireCount_d  = wr ? retireCount_q + CNT_WIDTH'(1) : retireCount_q;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (wr) begin
      regFile_q[bus.iWriteAddr] <= bus.iWriteData;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      halted_q       <= 1'b0;
      redirectEn_q   <= 1'b0;
      redirectAddr_q <= '0;
      retireCount_q  <= '0;
    end else begin
      halted_q       <= halted_d;
      redirectEn_q   <= redirectEn_d;
      redirectAddr_q <= redirectAddr_d;
      retireCount_q  <= retireCount_d;
    end
  end

  always_comb begin
    bus.oReadDataA = '0;
    if (bus.iReadAddrA != '0) begin
      if (wr && (bus.iWriteAddr == bus.iReadAddrA)) begin
        bus.oReadDataA = bus.iWriteData;
      end else begin
        bus.oReadDataA = regFile_q[bus.iReadAddrA];
      end
    end
  end

  always_comb begin
    bus.oReadDataB = '0;
    if (bus.iReadAddrB != '0) begin
      if (wr && (bus.iWriteAddr == bus.iReadAddrB)) begin
        bus.oReadDataB = bus.iWriteData;
      end else begin
        bus.oReadDataB = regFile_q[bus.iReadAddrB];
      end
    end
  end

  assign bus.oRedirectEn   = redirectEn_q;
  assign bus.oRedirectAddr = redirectAddr_q;
  assign bus.oHalted       = halted_q;
  assign bus.oRetireCount  = retireCount_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// Directed testbench for reg_file_wb: a full-width instance plus a 4-bit counter build for wrap.
module tb_reg_file_wb;
  logic clk;
  logic rstN;
  int   vectors;
  int   miscompares;

  reg_file_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
  reg_file_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  bus4 ();

  reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .iClk(clk), .iRst_n(rstN), .bus(bus)
  );

  reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .iClk(clk), .iRst_n(rstN), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic ret, input logic [31:0] ra, input logic halt,
                               input logic [4:0] rdA, input logic [4:0] rdB);
    bus.iWriteEn   = we;
    bus.iWriteAddr = wa;
    bus.iWriteData = wd;
    bus.iRetCmd    = ret;
    bus.iRetAddr   = ra;
    bus.iHalt      = halt;
    bus.iReadAddrA = rdA;
    bus.iReadAddrB = rdB;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    clk = 1'b0;
    rstN = 1'b0;
    vectors = 0;
    miscompares = 0;
    bus4.iWriteEn = 1'b0;  bus4.iWriteAddr = '0; bus4.iWriteData = '0;
    bus4.iRetCmd = 1'b0;   bus4.iRetAddr = '0;   bus4.iHalt = 1'b0;
    bus4.iReadAddrA = 5'd1; bus4.iReadAddrB = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0);

    // Reset: every index reads zero on both ports, status at reset values.
    for (int i = 0; i < 32; i++) begin
      bus.iReadAddrA = 5'(i);
      bus.iReadAddrB = 5'(31 - i);
      #1;
      checkOutput($sformatf("rst_rdA_%0d", i), 64'(bus.oReadDataA), 64'h0);
      checkOutput($sformatf("rst_rdB_%0d", 31 - i), 64'(bus.oReadDataB), 64'h0);
    end
    checkOutput("rst_halted", 64'(bus.oHalted), 64'h0);
    checkOutput("rst_redirEn", 64'(bus.oRedirectEn), 64'h0);
    checkOutput("rst_redirAddr", 64'(bus.oRedirectAddr), 64'h0);
    checkOutput("rst_count", 64'(bus.oRetireCount), 64'h0);

    @(negedge clk);
    rstN = 1'b1;
    tick();

    // Write r5 with both ports bypassing in the same cycle.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 5'd5, 5'd5);
    checkOutput("bypassA_r5", 64'(bus.oReadDataA), 64'hDEADBEEF);
    checkOutput("bypassB_r5", 64'(bus.oReadDataB), 64'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0, 5'd5, 5'd0);
    checkOutput("array_r5", 64'(bus.oReadDataA), 64'hDEADBEEF);
    checkOutput("count_after_r5", 64'(bus.oRetireCount), 64'h1);

    // r0 writes are ignored and not counted.
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkOutput("r0_bypassA", 64'(bus.oReadDataA), 64'h0);
    checkOutput("r0_bypassB", 64'(bus.oReadDataB), 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd5);
    checkOutput("r0_array", 64'(bus.oReadDataA), 64'h0);
    checkOutput("r0_count", 64'(bus.oRetireCount), 64'h1);

    // Bypass on A only; B reads a different stored register.
    applyStimulus(1'b1, 5'd9, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 5'd9, 5'd5);
    checkOutput("r9_bypassA", 64'(bus.oReadDataA), 64'h0BADF00D);
    checkOutput("r5_arrayB", 64'(bus.oReadDataB), 64'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd5, 5'd9);
    checkOutput("r9_arrayB", 64'(bus.oReadDataB), 64'h0BADF00D);
    checkOutput("count_2", 64'(bus.oRetireCount), 64'h2);

    // Single return command: one-cycle strobe, address held afterwards.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h00400020, 1'b0, 5'd0, 5'd0);
    checkOutput("redir_not_yet", 64'(bus.oRedirectEn), 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    checkOutput("redir_en", 64'(bus.oRedirectEn), 64'h1);
    checkOutput("redir_addr", 64'(bus.oRedirectAddr), 64'h00400020);
    tick();
    checkOutput("redir_en_drop", 64'(bus.oRedirectEn), 64'h0);
    checkOutput("redir_addr_hold", 64'(bus.oRedirectAddr), 64'h00400020);

    // Back-to-back return commands.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h00000200, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h00000300, 1'b0, 5'd0, 5'd0);
    checkOutput("b2b_en1", 64'(bus.oRedirectEn), 64'h1);
    checkOutput("b2b_addr1", 64'(bus.oRedirectAddr), 64'h200);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0);
    checkOutput("b2b_en2", 64'(bus.oRedirectEn), 64'h1);
    checkOutput("b2b_addr2", 64'(bus.oRedirectAddr), 64'h300);
    tick();
    checkOutput("b2b_drop", 64'(bus.oRedirectEn), 64'h0);

    // Halt together with a write and a return: all three take effect.
    applyStimulus(1'b1, 5'd7, 32'h000000A5, 1'b1, 32'h00000100, 1'b1, 5'd7, 5'd0);
    checkOutput("halt_cycle_bypass", 64'(bus.oReadDataA), 64'hA5);
    checkOutput("halt_not_yet", 64'(bus.oHalted), 64'h0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h000000FF, 1'b1, 32'h00000555, 1'b0, 5'd7, 5'd9);
    checkOutput("halted", 64'(bus.oHalted), 64'h1);
    checkOutput("halt_redir_en", 64'(bus.oRedirectEn), 64'h1);
    checkOutput("halt_redir_addr", 64'(bus.oRedirectAddr), 64'h100);
    checkOutput("halt_count", 64'(bus.oRetireCount), 64'h3);
    checkOutput("halted_no_bypass", 64'(bus.oReadDataA), 64'hA5);
    checkOutput("halted_read_r9", 64'(bus.oReadDataB), 64'h0BADF00D);
    tick();
    checkOutput("halted_r7_kept", 64'(bus.oReadDataA), 64'hA5);
    checkOutput("halted_no_strobe", 64'(bus.oRedirectEn), 64'h0);
    checkOutput("halted_addr_hold", 64'(bus.oRedirectAddr), 64'h100);
    checkOutput("halted_count_frozen", 64'(bus.oRetireCount), 64'h3);
    checkOutput("halted_sticky", 64'(bus.oHalted), 64'h1);

    // Asynchronous reset mid-run clears everything immediately, with no bypass.
    applyStimulus(1'b1, 5'd5, 32'h77777777, 1'b0, 32'h0, 1'b0, 5'd5, 5'd7);
    rstN = 1'b0;
    #1;
    checkOutput("mrst_rdA_r5", 64'(bus.oReadDataA), 64'h0);
    checkOutput("mrst_rdB_r7", 64'(bus.oReadDataB), 64'h0);
    checkOutput("mrst_halted", 64'(bus.oHalted), 64'h0);
    checkOutput("mrst_addr", 64'(bus.oRedirectAddr), 64'h0);
    checkOutput("mrst_count", 64'(bus.oRetireCount), 64'h0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'h00000042, 1'b0, 32'h0, 1'b0, 5'd5, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd5, 5'd0);
    checkOutput("post_rst_r5", 64'(bus.oReadDataA), 64'h42);
    checkOutput("post_rst_count", 64'(bus.oRetireCount), 64'h1);

    // 4-bit counter build: 16 commits from zero wrap back to zero.
    checkOutput("cnt4_start", 64'(bus4.oRetireCount), 64'h0);
    for (int i = 0; i < 16; i++) begin
      bus4.iWriteEn   = 1'b1;
      bus4.iWriteAddr = 5'd1;
      bus4.iWriteData = 32'(i + 1);
      tick();
      if (i == 14) begin
        checkOutput("cnt4_at_15", 64'(bus4.oRetireCount), 64'hF);
      end
    end
    bus4.iWriteEn = 1'b0;
    #1;
    checkOutput("cnt4_wrapped", 64'(bus4.oRetireCount), 64'h0);
    checkOutput("cnt4_r1", 64'(bus4.oReadDataA), 64'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
